// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_wr_arbiter_pkg: requester encoding and defaults shared by the writeback-stage blocks
package regfile_wr_arbiter_pkg;
  typedef enum logic {REQ_ALU = 1'b0, REQ_LD = 1'b1} req_e;
  localparam int STARVE_MAX_DEF = 3;
endpackage

// File: rtl/regfile_defines.sv
// regfile_defines: shared register-file geometry used by the writeback-stage blocks
`ifndef REGFILE_DEFINES_SV
`define REGFILE_DEFINES_SV
`define ASIZE 5
`define DSIZE 32
`define NREG 32
`endif

// File: rtl/regfile_wr_arbiter_prio.sv
// wr_prio_sel: load-first grant with a forced ALU win once the starvation count saturates
module wr_prio_sel
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int SW = 2,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          alu_valid,
  input  logic          ld_valid,
  input  logic [SW-1:0] starve_cnt,
  output logic [1:0]    grant
);
  logic force_alu;
  assign force_alu = alu_valid && starve_cnt == SW'(STARVE_MAX);
  always_comb begin
    grant = '0;
    grant[REQ_ALU] = alu_valid && (!ld_valid || force_alu);
    grant[REQ_LD] = ld_valid && !force_alu;
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: two-requester writeback arbiter driving a registered regfile write port
// REGFILE_WR_ARB_R0_DROP_EN: accept but never issue writes to register 0
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int AW = `ASIZE,
  parameter int DW = `DSIZE,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic [SW-1:0] starve_cnt
);
  logic [1:0] grant;
  logic acc, issue, wen_q;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  wr_prio_sel #(.SW(SW), .STARVE_MAX(STARVE_MAX)) u_sel (
    .alu_valid(alu_valid),
    .ld_valid(ld_valid),
    .starve_cnt(starve_cnt),
    .grant(grant)
  );
  assign alu_ready = grant[REQ_ALU] && !rst;
  assign ld_ready = grant[REQ_LD] && !rst;
  assign acc = alu_ready || ld_ready;
  assign acc_addr = ld_ready ? ld_addr : alu_addr;
  assign acc_data = ld_ready ? ld_data : alu_data;
`ifdef REGFILE_WR_ARB_R0_DROP_EN
  assign issue = acc && acc_addr != '0;
`else
  assign issue = acc;
`endif
  // Reset also masks a write already sitting in the output register
  assign wen = wen_q && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      starve_cnt <= '0;
    end else begin
      wen_q <= issue;
      if (issue) begin
        waddr <= acc_addr;
        wdata <= acc_data;
      end
      if (alu_ready) starve_cnt <= '0;
      else if (alu_valid && ld_ready && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed checks of arbitration, starvation guard, output stage and reset
module tb_regfile_wr_arbiter;
  logic clk = 0, rst = 1;
  logic alu_valid = 0, ld_valid = 0;
  logic [4:0] alu_addr = 0, ld_addr = 0, waddr;
  logic [31:0] alu_data = 0, ld_data = 0, wdata;
  logic alu_ready, ld_ready, wen;
  logic [1:0] starve_cnt;
  logic [31:0] rf [32];
  int tests = 0, fails = 0;

  regfile_wr_arbiter #(.AW(5), .DW(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .wen(wen), .waddr(waddr), .wdata(wdata), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;
  initial for (int i = 0; i < 32; i++) rf[i] = 0;
  always @(posedge clk) if (wen) rf[waddr] <= wdata;

  task automatic test_reset;
    rst = 1; alu_valid = 1; ld_valid = 1; alu_addr = 5; ld_addr = 6; alu_data = 1; ld_data = 2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if ({alu_ready, ld_ready, wen} !== 3'b000 || waddr !== 0 || wdata !== 0 || starve_cnt !== 0) begin
        fails++;
        $display("FAIL reset c%0d: rdy=%b%b wen=%b waddr=%0d wdata=%h cnt=%0d, want all 0", c, alu_ready, ld_ready, wen, waddr, wdata, starve_cnt);
      end
    end
    alu_valid = 0; ld_valid = 0; rst = 0;
  endtask

  task automatic test_single;
    @(negedge clk);
    alu_valid = 1; alu_addr = 4; alu_data = 32'h11;
    #1 tests++;
    if (alu_ready !== 1 || ld_ready !== 0) begin fails++; $display("FAIL single_ready: alu=%b ld=%b, want 1 0", alu_ready, ld_ready); end
    @(negedge clk);
    alu_valid = 0;
    tests++;
    if (wen !== 1 || waddr !== 4 || wdata !== 32'h11) begin fails++; $display("FAIL single_write: wen=%b waddr=%0d wdata=%h, want 1 4 11", wen, waddr, wdata); end
    @(negedge clk);
    tests++;
    if (wen !== 0 || waddr !== 4 || wdata !== 32'h11) begin fails++; $display("FAIL single_idle: wen=%b waddr=%0d wdata=%h, want 0 4 11 held", wen, waddr, wdata); end
  endtask

  task automatic test_contention;
    logic exp_alu;
    logic [31:0] exp_d;
    int k = 0;
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1; alu_addr = 10; alu_data = 32'h200 + k;
      ld_valid = 1; ld_addr = 11; ld_data = 32'h100 + i;
      exp_alu = (i % 4) == 3;
      exp_d = exp_alu ? 32'h200 + k : 32'h100 + i;
      #1 tests++;
      if (alu_ready !== exp_alu || ld_ready !== !exp_alu || starve_cnt !== 2'(i % 4)) begin
        fails++;
        $display("FAIL contention_grant %0d: alu=%b ld=%b cnt=%0d, want %b %b %0d", i, alu_ready, ld_ready, starve_cnt, exp_alu, !exp_alu, i % 4);
      end
      @(negedge clk);
      tests++;
      if (wen !== 1 || wdata !== exp_d) begin fails++; $display("FAIL contention_write %0d: wen=%b wdata=%h, want 1 %h", i, wen, wdata, exp_d); end
      if (exp_alu) k++;
    end
    alu_valid = 0; ld_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_same_addr;
    alu_valid = 1; alu_addr = 8; alu_data = 32'h5;
    ld_valid = 1; ld_addr = 8; ld_data = 32'h9;
    #1 tests++;
    if (ld_ready !== 1 || alu_ready !== 0) begin fails++; $display("FAIL same_addr_prio: alu=%b ld=%b, want 0 1", alu_ready, ld_ready); end
    @(negedge clk);
    ld_valid = 0;
    tests++;
    if (wen !== 1 || waddr !== 8 || wdata !== 32'h9) begin fails++; $display("FAIL same_addr_first: wen=%b waddr=%0d wdata=%h, want 1 8 9", wen, waddr, wdata); end
    #1 tests++;
    if (alu_ready !== 1) begin fails++; $display("FAIL same_addr_alu_ready: got %b want 1", alu_ready); end
    @(negedge clk);
    alu_valid = 0;
    tests++;
    if (wen !== 1 || waddr !== 8 || wdata !== 32'h5) begin fails++; $display("FAIL same_addr_second: wen=%b waddr=%0d wdata=%h, want 1 8 5", wen, waddr, wdata); end
    @(negedge clk);
    tests++;
    if (rf[8] !== 32'h5) begin fails++; $display("FAIL same_addr_final: rf[8]=%h want 5", rf[8]); end
  endtask

  task automatic test_mid_reset;
    ld_valid = 1; ld_addr = 3; ld_data = 32'h7;
    #1 tests++;
    if (ld_ready !== 1) begin fails++; $display("FAIL mid_reset_accept: ld_ready=%b want 1", ld_ready); end
    @(posedge clk);
    #1 rst = 1; ld_valid = 0;
    @(negedge clk);
    tests++;
    if (wen !== 0) begin fails++; $display("FAIL mid_reset_n1: wen=%b want 0", wen); end
    @(negedge clk);
    tests++;
    if (wen !== 0 || waddr !== 0 || wdata !== 0 || starve_cnt !== 0) begin fails++; $display("FAIL mid_reset_n2: wen=%b waddr=%0d wdata=%h cnt=%0d want 0 0 0 0", wen, waddr, wdata, starve_cnt); end
    rst = 0;
    @(negedge clk);
    tests++;
    if (rf[3] !== 0 || wen !== 0) begin fails++; $display("FAIL mid_reset_rf: rf[3]=%h wen=%b want 0 0", rf[3], wen); end
  endtask

  task automatic test_back_to_back;
    alu_valid = 1; alu_addr = 1; alu_data = 32'hA;
    @(negedge clk);
    alu_valid = 0; ld_valid = 1; ld_addr = 2; ld_data = 32'hB;
    tests++;
    if (wen !== 1 || waddr !== 1 || wdata !== 32'hA) begin fails++; $display("FAIL b2b_first: wen=%b waddr=%0d wdata=%h want 1 1 a", wen, waddr, wdata); end
    @(negedge clk);
    ld_valid = 0;
    tests++;
    if (wen !== 1 || waddr !== 2 || wdata !== 32'hB) begin fails++; $display("FAIL b2b_second: wen=%b waddr=%0d wdata=%h want 1 2 b", wen, waddr, wdata); end
    @(negedge clk);
  endtask

  task automatic test_r0;
    alu_valid = 1; alu_addr = 0; alu_data = 32'hFF;
    #1 tests++;
    if (alu_ready !== 1) begin fails++; $display("FAIL r0_ready: alu_ready=%b want 1", alu_ready); end
    @(negedge clk);
    alu_valid = 0;
    tests++;
`ifdef REGFILE_WR_ARB_R0_DROP_EN
    if (wen !== 0) begin fails++; $display("FAIL r0_drop: wen=%b want 0", wen); end
`else
    if (wen !== 1 || waddr !== 0 || wdata !== 32'hFF) begin fails++; $display("FAIL r0_write: wen=%b waddr=%0d wdata=%h want 1 0 ff", wen, waddr, wdata); end
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_same_addr;
    test_mid_reset;
    test_back_to_back;
    test_r0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
